// File: rtl/sam_asic_pkg.sv
// Shared SAM ASIC definitions: fetch FSM states, video mode codes and
// screen layout constants used by the video fetch stage.
package sam_asic_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    localparam logic [1:0] MODE1 = 2'b00;
    localparam logic [1:0] MODE2 = 2'b01;
    localparam logic [1:0] MODE3 = 2'b10;
    localparam logic [1:0] MODE4 = 2'b11;

    localparam int          MODE4_LINE_BYTES  = 128;
    localparam logic [13:0] MODE1_ATTR_OFFSET = 14'h1800;

endpackage

// File: rtl/sam_fetch_fifo.sv
// Single-clock show-ahead byte FIFO with occupancy count and synchronous flush.
// The head byte is presented combinationally; an empty FIFO presents 8'h00.
module sam_fetch_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !flush && (count_reg != FULL_COUNT);
    assign do_pop  = pop  && !flush && (count_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    assign empty = (count_reg == '0);
    assign dout  = empty ? 8'h00 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/sam_video_fetch.sv
// SAM Coupe video fetch: grants the ASIC one SRAM clock per fetch slot and buffers line bytes.
// SAM_FETCH_MODE12_EN adds Spectrum-layout fetch (bitmap + attribute) for modes 1/2.
module sam_video_fetch
    import sam_asic_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int SLOT_PERIOD  = 4,
    parameter int ACTIVE_LINES = 192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  screen_page,
    input  logic [1:0]  vidmode,
    input  logic        line_start,
    input  logic [7:0]  line_num,
    output logic        whichturn,
    output logic [18:0] vramaddr,
    input  logic [7:0]  data_to_asic,
    input  logic        pix_rd,
    output logic [7:0]  pix_data,
    output logic        pix_empty,
    output logic        line_done
);

    localparam int PW = (SLOT_PERIOD > 1) ? $clog2(SLOT_PERIOD) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] PHASE_MAX    = PW'(SLOT_PERIOD - 1);
    localparam logic [CW-1:0] DEPTH_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [8:0]    ACTIVE_LIMIT = 9'(ACTIVE_LINES);

    fetch_state_e  state_reg;
    logic [PW-1:0] phase_reg;
    logic [6:0]    byte_cnt_reg;
    logic [7:0]    line_reg;
    logic          whichturn_reg;
    logic [18:0]   vramaddr_reg;
    logic          line_done_reg;

    logic [CW-1:0] fifo_count;
    logic          start_ok;
    logic          restart;
    logic          capture;
    logic [18:0]   addr_next;
    logic [6:0]    last_idx;

    assign start_ok = line_start && ({1'b0, line_num} < ACTIVE_LIMIT);
    assign restart  = line_start && ((state_reg == ST_FETCH) || start_ok);
    // A capture coinciding with a restart belongs to the abandoned line.
    assign capture  = whichturn_reg && !line_start;

`ifdef SAM_FETCH_MODE12_EN
    logic [1:0] mode_reg;

    always_comb begin
        addr_next = {screen_page[4:1], line_reg, byte_cnt_reg};
        last_idx  = 7'(MODE4_LINE_BYTES - 1);
        if (mode_reg == MODE1 || mode_reg == MODE2) begin
            // Even byte index fetches the bitmap, odd the attribute of the same column.
            last_idx = 7'd63;
            if (!byte_cnt_reg[0])
                addr_next = {screen_page, 1'b0, line_reg[7:6], line_reg[2:0],
                             line_reg[5:3], byte_cnt_reg[5:1]};
            else
                addr_next = {screen_page,
                             MODE1_ATTR_OFFSET | {4'b0000, line_reg[7:3], byte_cnt_reg[5:1]}};
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{vidmode, screen_page[0]};

    always_comb begin
        addr_next = {screen_page[4:1], line_reg, byte_cnt_reg};
        last_idx  = 7'(MODE4_LINE_BYTES - 1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= '0;
            byte_cnt_reg  <= '0;
            line_reg      <= '0;
            whichturn_reg <= 1'b0;
            vramaddr_reg  <= '0;
            line_done_reg <= 1'b0;
`ifdef SAM_FETCH_MODE12_EN
            mode_reg      <= MODE4;
`endif
        end else begin
            whichturn_reg <= 1'b0;
            line_done_reg <= 1'b0;
            if (restart) begin
                state_reg    <= start_ok ? ST_FETCH : ST_IDLE;
                line_reg     <= line_num;
                byte_cnt_reg <= '0;
                phase_reg    <= '0;
`ifdef SAM_FETCH_MODE12_EN
                mode_reg     <= vidmode;
`endif
            end else if (state_reg == ST_FETCH) begin
                phase_reg <= (phase_reg == PHASE_MAX) ? '0 : phase_reg + 1'b1;
                // Previous capture has always landed by phase 0, so the count is exact.
                if (phase_reg == '0 && fifo_count < DEPTH_COUNT) begin
                    whichturn_reg <= 1'b1;
                    vramaddr_reg  <= addr_next;
                end
                if (capture) begin
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                    if (byte_cnt_reg == last_idx) begin
                        line_done_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
            end
        end
    end

    sam_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (restart),
        .push  (capture),
        .din   (data_to_asic),
        .pop   (pix_rd),
        .dout  (pix_data),
        .empty (pix_empty),
        .count (fifo_count)
    );

    assign whichturn = whichturn_reg;
    assign vramaddr  = vramaddr_reg;
    assign line_done = line_done_reg;

endmodule
